// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file read arbiter.
package regfile_arb_pkg;

   localparam int unsigned SEL_W_DEF  = 5;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SELECT = 2'b01,
      RESP   = 2'b10
   } state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned num_req);
      return (num_req <= 2) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/rr_priority_arb.sv
// Combinational round-robin pick: first active request at or above the
// pointer, wrapping past the top requester back to zero.
module rr_priority_arb #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_gnt_idx,
   output logic               o_any
);

   logic [31:0] w_pos;

   // Walk the requesters starting at the pointer; the first hit wins.
   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_any     = 1'b0;
      w_pos     = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         w_pos = 32'(i_ptr) + off;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         if (!o_any && i_req[w_pos[ID_W-1:0]]) begin
            o_any                    = 1'b1;
            o_gnt[w_pos[ID_W-1:0]]   = 1'b1;
            o_gnt_idx                = w_pos[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin scheduler sharing one 32:1 register-file read mux among
// NUM_REQ requesters. Each access runs IDLE (grant) -> SELECT (mux settles
// on a registered select) -> RESP (captured data held until consumed).
module regfile_read_arbiter
   import regfile_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned DATA_W  = DATA_W_DEF,
   parameter  int unsigned SEL_W   = SEL_W_DEF,
   localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*SEL_W-1:0] req_sel,
   output logic [SEL_W-1:0]         mux_sel,
   input  logic [DATA_W-1:0]        mux_data,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DATA_W-1:0]        rsp_data,
   input  logic                     rsp_ready
);

   state_t              r_state;
   state_t              w_next_state;

   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_grant_id;
   logic [SEL_W-1:0]    r_mux_sel;
   logic                r_rsp_valid;
   logic [ID_W-1:0]     r_rsp_id;
   logic [DATA_W-1:0]   r_rsp_data;

   logic [NUM_REQ-1:0]  w_gnt;
   logic [ID_W-1:0]     w_gnt_idx;
   logic                w_any;
   logic                w_accept;
   logic [SEL_W-1:0]    w_win_sel;
   logic [ID_W-1:0]     w_next_ptr;

   rr_priority_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_priority_arb (
      .i_req     (req_valid),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_any)
   );

   // Route the winning requester's source index (grant is one-hot).
   always_comb begin
      w_win_sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_win_sel = w_win_sel | req_sel[i*SEL_W +: SEL_W];
         end
      end
   end

   // Pointer moves one past the winner, wrapping after the top requester.
   always_comb begin
      if (w_gnt_idx == ID_W'(NUM_REQ - 1)) begin
         w_next_ptr = '0;
      end else begin
         w_next_ptr = w_gnt_idx + ID_W'(1);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; unused encodings fall back to IDLE.
   always_comb begin
      w_next_state = IDLE;
      case (r_state)
         IDLE:    w_next_state = w_any ? SELECT : IDLE;
         SELECT:  w_next_state = RESP;
         RESP:    w_next_state = rsp_ready ? IDLE : RESP;
         default: w_next_state = IDLE;
      endcase
   end

   // Outputs decoded from state: grants are only offered while idle.
   always_comb begin
      req_ready = '0;
      w_accept  = 1'b0;
      if (r_state == IDLE) begin
         req_ready = w_gnt;
         w_accept  = w_any;
      end
   end

   // Datapath registers: select and pointer on accept, capture in SELECT,
   // release in RESP once the consumer takes the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_grant_id  <= '0;
         r_mux_sel   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mux_sel  <= w_win_sel;
                  r_grant_id <= w_gnt_idx;
                  r_ptr      <= w_next_ptr;
               end
            end
            SELECT: begin
               r_rsp_data  <= mux_data;
               r_rsp_id    <= r_grant_id;
               r_rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mux_sel   = r_mux_sel;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;

endmodule
